// File: rtl/phys_reg_free_list.sv
// Circular free list of physical registers with speculative and committed heads.
// Grants one register per cycle, marks it busy, and rolls back uncommitted grants on flush.
module phys_reg_free_list #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_ARCH_REGS = 32,
    parameter int LOG_PHYS      = $clog2(NUM_PHYS_REGS)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Alloc_IN,
    output logic                AllocReady_OUT,
    output logic [LOG_PHYS-1:0] AllocReg_OUT,
    input  logic                Commit_IN,
    input  logic                Free_IN,
    input  logic [LOG_PHYS-1:0] FreeReg_IN,
    input  logic                Flush_IN,
    output logic [LOG_PHYS-1:0] BusyReg_OUT,
    output logic                SetBusy_OUT,
    output logic                BusyValue_OUT,
    output logic [LOG_PHYS:0]   FreeCount_OUT,
    output logic                Overflow_OUT,
    output logic                Underflow_OUT
);

    localparam logic [LOG_PHYS:0] PTR_ONE  = (LOG_PHYS+1)'(1);
    localparam logic [LOG_PHYS:0] FULL_CNT = (LOG_PHYS+1)'(NUM_PHYS_REGS);
    localparam logic [LOG_PHYS:0] INIT_TAIL = (LOG_PHYS+1)'(NUM_PHYS_REGS - NUM_ARCH_REGS);

    logic [LOG_PHYS-1:0] r_fl [NUM_PHYS_REGS];
    logic [LOG_PHYS:0]   r_head;
    logic [LOG_PHYS:0]   r_chead;
    logic [LOG_PHYS:0]   r_tail;
    logic                r_ovf;
    logic                r_udf;

    logic                w_empty;
    logic                w_full;
    logic                w_acc;
    logic                w_commit_ok;
    logic                w_free_ok;
    logic [LOG_PHYS:0]   w_chead_nxt;
    logic [LOG_PHYS:0]   w_head_nxt;

    always_comb begin
        w_empty     = (r_head == r_tail);
        w_full      = ((r_tail - r_head) == FULL_CNT);
        w_acc       = Alloc_IN & ~w_empty & ~Flush_IN;
        w_commit_ok = Commit_IN & (r_head != r_chead);
        w_free_ok   = Free_IN & ~w_full;
        w_chead_nxt = r_chead;
        if (w_commit_ok)
            w_chead_nxt = r_chead + PTR_ONE;
        // Flush rolls back to the committed head, including this cycle's commit.
        w_head_nxt = r_head;
        if (Flush_IN)
            w_head_nxt = w_chead_nxt;
        else if (w_acc)
            w_head_nxt = r_head + PTR_ONE;
    end

    assign AllocReady_OUT = ~w_empty;
    assign AllocReg_OUT   = r_fl[r_head[LOG_PHYS-1:0]];
    assign SetBusy_OUT    = w_acc;
    assign BusyReg_OUT    = AllocReg_OUT;
    assign BusyValue_OUT  = 1'b1;
    assign FreeCount_OUT  = r_tail - r_head;
    assign Overflow_OUT   = r_ovf;
    assign Underflow_OUT  = r_udf;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_PHYS_REGS; i++) begin
                if (i < NUM_PHYS_REGS - NUM_ARCH_REGS)
                    r_fl[i] <= LOG_PHYS'(NUM_ARCH_REGS + i);
                else
                    r_fl[i] <= '0;
            end
            r_head  <= '0;
            r_chead <= '0;
            r_tail  <= INIT_TAIL;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_head  <= w_head_nxt;
            r_chead <= w_chead_nxt;
            if (w_free_ok) begin
                r_fl[r_tail[LOG_PHYS-1:0]] <= FreeReg_IN;
                r_tail <= r_tail + PTR_ONE;
            end
            if (Free_IN && w_full)
                r_ovf <= 1'b1;
            if (Commit_IN && !w_commit_ok)
                r_udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: drain, refill, flush rollback, error flags, reset.
module tb_phys_reg_free_list;

    localparam int NP = 64;
    localparam int LP = 6;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          Alloc_IN;
    logic          AllocReady_OUT;
    logic [LP-1:0] AllocReg_OUT;
    logic          Commit_IN;
    logic          Free_IN;
    logic [LP-1:0] FreeReg_IN;
    logic          Flush_IN;
    logic [LP-1:0] BusyReg_OUT;
    logic          SetBusy_OUT;
    logic          BusyValue_OUT;
    logic [LP:0]   FreeCount_OUT;
    logic          Overflow_OUT;
    logic          Underflow_OUT;

    int n_vec = 0;
    int n_err = 0;

    phys_reg_free_list #(.NUM_PHYS_REGS(NP), .NUM_ARCH_REGS(32)) dut (
        .CLK(CLK), .RESET(RESET), .Alloc_IN(Alloc_IN), .AllocReady_OUT(AllocReady_OUT),
        .AllocReg_OUT(AllocReg_OUT), .Commit_IN(Commit_IN), .Free_IN(Free_IN),
        .FreeReg_IN(FreeReg_IN), .Flush_IN(Flush_IN), .BusyReg_OUT(BusyReg_OUT),
        .SetBusy_OUT(SetBusy_OUT), .BusyValue_OUT(BusyValue_OUT),
        .FreeCount_OUT(FreeCount_OUT), .Overflow_OUT(Overflow_OUT),
        .Underflow_OUT(Underflow_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Alloc_IN = 0; Commit_IN = 0; Free_IN = 0; FreeReg_IN = '0; Flush_IN = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        idle();
        RESET = 0;
        repeat (cycles) tick();
        RESET = 1;
    endtask

    task automatic chk_reset_state(input string tag);
        #1;
        chk({tag, "_cnt"}, int'(FreeCount_OUT), 32);
        chk({tag, "_rdy"}, int'(AllocReady_OUT), 1);
        chk({tag, "_reg"}, int'(AllocReg_OUT), 32);
        chk({tag, "_ovf"}, int'(Overflow_OUT), 0);
        chk({tag, "_udf"}, int'(Underflow_OUT), 0);
    endtask

    initial begin
        idle();
        RESET = 0;
        tick();

        // Reset
        do_reset(2);
        chk_reset_state("rst");

        // Drain: 32 grants then empty
        for (int i = 0; i < 33; i++) begin
            Alloc_IN = 1;
            #1;
            if (i < 32) begin
                chk($sformatf("drain_reg%0d", i), int'(AllocReg_OUT), 32 + i);
                chk($sformatf("drain_busy%0d", i), int'(SetBusy_OUT), 1);
                chk($sformatf("drain_breg%0d", i), int'(BusyReg_OUT), 32 + i);
            end else begin
                chk("empty_rdy", int'(AllocReady_OUT), 0);
                chk("empty_busy", int'(SetBusy_OUT), 0);
                chk("empty_cnt", int'(FreeCount_OUT), 0);
            end
            tick();
        end
        chk("busy_val", int'(BusyValue_OUT), 1);

        // Refill while empty: no bypass
        Alloc_IN = 1; Free_IN = 1; FreeReg_IN = 5;
        #1;
        chk("refill_nogrant", int'(SetBusy_OUT), 0);
        tick();
        idle();
        #1;
        chk("refill_rdy", int'(AllocReady_OUT), 1);
        chk("refill_reg", int'(AllocReg_OUT), 5);
        chk("refill_cnt", int'(FreeCount_OUT), 1);

        // Flush rollback
        do_reset(1);
        Alloc_IN = 1;
        repeat (3) tick();
        idle();
        Commit_IN = 1; tick();
        idle();
        Flush_IN = 1; Alloc_IN = 1;
        #1;
        chk("flush_suppress", int'(SetBusy_OUT), 0);
        tick();
        idle();
        #1;
        chk("flush_cnt", int'(FreeCount_OUT), 31);
        chk("flush_reg", int'(AllocReg_OUT), 33);

        // Alloc + free same cycle: count unchanged
        Alloc_IN = 1; Free_IN = 1; FreeReg_IN = 7;
        #1;
        chk("af_busy", int'(SetBusy_OUT), 1);
        chk("af_breg", int'(BusyReg_OUT), 33);
        tick();
        idle();
        #1;
        chk("af_cnt", int'(FreeCount_OUT), 31);
        chk("af_reg", int'(AllocReg_OUT), 34);

        // Commit with flush: commit lands first (head 3, chead 1 -> both 2)
        Alloc_IN = 1; tick();
        idle();
        Commit_IN = 1; Flush_IN = 1; tick();
        idle();
        #1;
        chk("cf_cnt", int'(FreeCount_OUT), 31);
        chk("cf_reg", int'(AllocReg_OUT), 34);
        chk("cf_udf", int'(Underflow_OUT), 0);

        // Overflow
        do_reset(1);
        for (int i = 0; i < 32; i++) begin
            Free_IN = 1; FreeReg_IN = LP'(i);
            tick();
        end
        idle();
        #1;
        chk("full_cnt", int'(FreeCount_OUT), 64);
        chk("full_ovf_pre", int'(Overflow_OUT), 0);
        Free_IN = 1; FreeReg_IN = 9; tick();
        idle();
        #1;
        chk("ovf_flag", int'(Overflow_OUT), 1);
        chk("ovf_cnt", int'(FreeCount_OUT), 64);

        // Underflow
        chk("udf_pre", int'(Underflow_OUT), 0);
        Commit_IN = 1; tick();
        idle();
        #1;
        chk("udf_flag", int'(Underflow_OUT), 1);
        tick();
        chk("ovf_sticky", int'(Overflow_OUT), 1);

        // Reset mid-operation overrides alloc/flush
        do_reset(1);
        Alloc_IN = 1;
        repeat (10) tick();
        #1;
        chk("mid_cnt", int'(FreeCount_OUT), 22);
        RESET = 0; Alloc_IN = 1; Flush_IN = 1;
        #1;
        chk("mid_nobusy", int'(SetBusy_OUT), 0);
        tick();
        idle();
        RESET = 1;
        chk_reset_state("mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Allocator and scheduler for the physical register file. It owns the pool of free physical registers and hands one to rename each cycle on request.
- Drives the register file's busy-set port, so every newly allocated register is marked busy. Registers released at commit return to the pool.
- Speculative allocations are rolled back on a pipeline flush by restoring the head pointer to the last committed position (retirement-ordered circular free list).

Parameters:
- NUM_PHYS_REGS, 64, total physical registers; must be a power of 2. LOG_PHYS = $clog2(NUM_PHYS_REGS).
- NUM_ARCH_REGS, 32, architectural registers. At reset, physical regs 0..NUM_ARCH_REGS-1 are mapped and not free.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-low reset, sampled on posedge CLK.
- Alloc_IN  in  1  rename requests one free register this cycle.
- AllocReady_OUT  out  1  free list non-empty; an allocation is accepted this cycle.
- AllocReg_OUT  out  LOG_PHYS  register granted (entry at head); valid when AllocReady_OUT=1.
- Commit_IN  in  1  oldest in-flight allocation has retired.
- Free_IN  in  1  release a register to the pool.
- FreeReg_IN  in  LOG_PHYS  register released.
- Flush_IN  in  1  squash all uncommitted allocations.
- BusyReg_OUT  out  LOG_PHYS  to register file busy port.
- SetBusy_OUT  out  1  to register file busy port.
- BusyValue_OUT  out  1  to register file busy port.
- FreeCount_OUT  out  LOG_PHYS+1  speculative free count (tail - head).
- Overflow_OUT  out  1  sticky error: Free_IN while full.
- Underflow_OUT  out  1  sticky error: Commit_IN with nothing in flight.

Behaviour:
- Storage:
  - Circular array FL[NUM_PHYS_REGS] of LOG_PHYS-bit entries.
  - Three pointers, each LOG_PHYS+1 bits wide, wrapping modulo 2*NUM_PHYS_REGS: head (speculative), chead (committed head), tail. The array index is the low LOG_PHYS bits.
- Empty: head==tail. Full: tail-head==NUM_PHYS_REGS. In-flight count: head-chead.
- Reset (RESET=0 at posedge):
  - FL[i]=NUM_ARCH_REGS+i for i<NUM_PHYS_REGS-NUM_ARCH_REGS; other entries 0.
  - head=chead=0, tail=NUM_PHYS_REGS-NUM_ARCH_REGS.
  - Overflow_OUT=Underflow_OUT=0.
  - After reset: FreeCount_OUT=32, AllocReady_OUT=1, AllocReg_OUT=32 (defaults).
  - Reset overrides every other input, including mid-flush.
- Combinational outputs:
  - AllocReady_OUT = (head!=tail).
  - AllocReg_OUT = FL[head].
  - acc = Alloc_IN & AllocReady_OUT & ~Flush_IN.
  - SetBusy_OUT = acc; BusyReg_OUT = AllocReg_OUT; BusyValue_OUT = 1.
  - Zero-cycle grant: the register file captures the busy bit on the same edge the head advances.
- Allocate: on acc, head<=head+1. Alloc_IN with AllocReady_OUT=0 is ignored (no busy set, no state change). Freed registers are not bypassed to the allocator: a free into an empty list becomes allocatable the next cycle.
- Free:
  - If not full: FL[tail]<=FreeReg_IN, tail<=tail+1.
  - If full: write dropped, Overflow_OUT<=1.
  - Free is applied regardless of Flush_IN, because commits are older than any flush.
- Commit:
  - If head!=chead: chead<=chead+1.
  - Else: ignored, Underflow_OUT<=1.
- Flush: head<=chead (after this cycle's commit increment, if any), which returns all uncommitted allocations to the pool. An allocation in the flush cycle is suppressed.
- Simultaneous events:
  - Alloc and free in the same cycle on a non-empty list: both apply; FreeCount is unchanged.
  - Commit with flush: commit applied first.
- Invariant: chead ≤ head ≤ tail (modular). FreeCount_OUT = tail-head, registered-state derived.
- No internal sequencing beyond the pointers. Error flags clear only on reset.

Test Plan:
- Reset: hold RESET=0 for 2 cycles -> FreeCount_OUT=32, AllocReady_OUT=1, AllocReg_OUT=32, both error flags 0.
- Drain: Alloc_IN=1 for 33 cycles -> grants 32..63 in order with SetBusy_OUT=1 and BusyReg_OUT matching each grant. Cycle 33: AllocReady_OUT=0, SetBusy_OUT=0, FreeCount_OUT=0.
- Refill while empty: Free_IN with FreeReg_IN=5 plus Alloc_IN=1 in the same cycle -> no grant that cycle. Next cycle AllocReady_OUT=1, AllocReg_OUT=5.
- Flush rollback: from reset, allocate 3 (32,33,34), Commit_IN once, then Flush_IN -> FreeCount_OUT=31, next grant is 33.
- Errors: from reset, Free_IN on 32 consecutive cycles -> Overflow_OUT=1 on the 33rd write attempt, FreeCount_OUT stays 64. Commit_IN with nothing in flight -> Underflow_OUT=1.
- Reset mid-operation: after 10 allocations, assert RESET=0 together with Alloc_IN=1 and Flush_IN=1 -> no busy set; state equals post-reset values next cycle.
